// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module      : spi_reg_pkg
// Description : Shared FSM encoding, command-field layout and the statistics
//               register address for the SPI register controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        AWAIT_DATA = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    localparam logic [6:0] STATS_ADDR   = 7'h7F;
    localparam int         CMD_WR_BIT   = 7;
    localparam int         CMD_ADDR_MSB = 6;
    localparam int         CMD_ADDR_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/spi_reg_arbiter.sv
// ============================================================================
// Module      : spi_reg_arbiter
// Description : Grants local-fabric accesses whenever no SPI commit is in
//               progress; issues a single acknowledge per held request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic loc_req,
    input  logic spi_commit,
    output logic grant,
    output logic loc_ack
);

    logic r_ack;

    // While the ack is out the requester is still holding loc_req, so mask it
    // to avoid granting the same request twice.
    assign grant   = loc_req && !spi_commit && !r_ack;
    assign loc_ack = r_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= grant;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_register_controller.sv
// ============================================================================
// Module      : spi_register_controller
// Description : Register bank shared between an SPI slave command/data stream
//               and a local-fabric port. Optional macro SPI_REG_STATS_EN
//               adds a read-only statistics word at address 7'h7F.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_register_controller
    import spi_reg_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int COMMAND_SIZE = 8,
    parameter int NUM_REGS     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [COMMAND_SIZE-1:0]       command,
    input  logic                          command_ready,
    input  logic [WORD_SIZE-1:0]          word_received,
    input  logic                          word_rx_complete,
    output logic [WORD_SIZE-1:0]          word_to_output,
    input  logic                          loc_req,
    input  logic                          loc_we,
    input  logic [6:0]                    loc_addr,
    input  logic [WORD_SIZE-1:0]          loc_wdata,
    output logic                          loc_ack,
    output logic [WORD_SIZE-1:0]          loc_rdata,
    output logic [NUM_REGS*WORD_SIZE-1:0] regs_flat,
    output logic                          spi_wr_strobe,
    output logic [6:0]                    spi_wr_addr,
    output logic                          bad_addr
);

    localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

    state_t                  r_state;
    state_t                  w_next;
    logic [COMMAND_SIZE-1:0] r_cmd_q;
    logic [WORD_SIZE-1:0]    r_wdata;
    logic [WORD_SIZE-1:0]    r_regs [NUM_REGS];

    logic [6:0]           w_cmd_addr;
    logic [6:0]           w_q_addr;
    logic                 w_q_wr;
    logic                 w_q_in_range;
    logic                 w_q_is_stats;
    logic                 w_commit;
    logic                 w_spi_we;
    logic                 w_bad;
    logic                 w_grant;
    logic [WORD_SIZE-1:0] w_spi_rd;
    logic [WORD_SIZE-1:0] w_loc_rd;

    assign w_cmd_addr   = command[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_q_addr     = r_cmd_q[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_q_wr       = r_cmd_q[CMD_WR_BIT];
    assign w_q_in_range = ({1'b0, w_q_addr} < NREGS8);
    assign w_commit     = (r_state == COMMIT);
    assign w_spi_we     = w_commit && w_q_wr && w_q_in_range;
    assign w_bad        = w_commit && !w_q_in_range && !w_q_is_stats;

`ifdef SPI_REG_STATS_EN
    logic [15:0]          r_txn_cnt;
    logic [7:0]           r_err_cnt;
    logic [WORD_SIZE-1:0] w_stats_word;

    assign w_q_is_stats = (w_q_addr == STATS_ADDR);
    assign w_stats_word = WORD_SIZE'({r_err_cnt, 8'h00, r_txn_cnt});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_txn_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_commit) r_txn_cnt <= r_txn_cnt + 16'd1;
            if (w_bad)    r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
`else
    assign w_q_is_stats = 1'b0;
`endif

    spi_reg_arbiter u_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .loc_req    (loc_req),
        .spi_commit (w_commit),
        .grant      (w_grant),
        .loc_ack    (loc_ack)
    );

    // A new command always restarts the transaction, even mid-word or in COMMIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (command_ready) w_next = AWAIT_DATA;
            AWAIT_DATA: begin
                if (command_ready)         w_next = AWAIT_DATA;
                else if (word_rx_complete) w_next = COMMIT;
            end
            COMMIT:     w_next = command_ready ? AWAIT_DATA : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_spi_rd = '0;
        w_loc_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_addr == 7'(i)) w_spi_rd = r_regs[i];
            if (loc_addr == 7'(i))   w_loc_rd = r_regs[i];
        end
`ifdef SPI_REG_STATS_EN
        if (w_cmd_addr == STATS_ADDR) w_spi_rd = w_stats_word;
        if (loc_addr == STATS_ADDR)   w_loc_rd = w_stats_word;
`endif
    end

    // SPI commit and local grant are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_spi_we && (w_q_addr == 7'(i)))
                    r_regs[i] <= r_wdata;
                else if (w_grant && loc_we && (loc_addr == 7'(i)))
                    r_regs[i] <= loc_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cmd_q        <= '0;
            r_wdata        <= '0;
            word_to_output <= '0;
            loc_rdata      <= '0;
            spi_wr_strobe  <= 1'b0;
            spi_wr_addr    <= '0;
            bad_addr       <= 1'b0;
        end else begin
            r_state       <= w_next;
            spi_wr_strobe <= w_spi_we;
            bad_addr      <= w_bad;
            if (command_ready) begin
                r_cmd_q        <= command;
                word_to_output <= w_spi_rd;
            end
            if ((r_state == AWAIT_DATA) && word_rx_complete && !command_ready)
                r_wdata <= word_received;
            if (w_spi_we)
                spi_wr_addr <= w_q_addr;
            if (w_grant)
                loc_rdata <= w_loc_rd;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*WORD_SIZE +: WORD_SIZE] = r_regs[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_register_controller.sv
// ============================================================================
// Module      : tb_spi_register_controller
// Description : Directed self-checking bench for spi_register_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_register_controller;
    import spi_reg_pkg::*;

    localparam int WS = 32;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    command;
    logic          command_ready;
    logic [WS-1:0] word_received;
    logic          word_rx_complete;
    logic [WS-1:0] word_to_output;
    logic          loc_req;
    logic          loc_we;
    logic [6:0]    loc_addr;
    logic [WS-1:0] loc_wdata;
    logic          loc_ack;
    logic [WS-1:0] loc_rdata;
    logic [NR*WS-1:0] regs_flat;
    logic          spi_wr_strobe;
    logic [6:0]    spi_wr_addr;
    logic          bad_addr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NR*WS-1:0] snap;

    spi_register_controller #(.WORD_SIZE(WS), .COMMAND_SIZE(8), .NUM_REGS(NR)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .command          (command),
        .command_ready    (command_ready),
        .word_received    (word_received),
        .word_rx_complete (word_rx_complete),
        .word_to_output   (word_to_output),
        .loc_req          (loc_req),
        .loc_we           (loc_we),
        .loc_addr         (loc_addr),
        .loc_wdata        (loc_wdata),
        .loc_ack          (loc_ack),
        .loc_rdata        (loc_rdata),
        .regs_flat        (regs_flat),
        .spi_wr_strobe    (spi_wr_strobe),
        .spi_wr_addr      (spi_wr_addr),
        .bad_addr         (bad_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WS-1:0] reg_of(input int i);
        return regs_flat[i*WS +: WS];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_cmd(input logic [7:0] c);
        command = c; command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
    endtask

    task automatic spi_word(input logic [WS-1:0] w);
        word_received = w; word_rx_complete = 1'b1;
        tick();
        word_rx_complete = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; command = '0; command_ready = 1'b0;
        word_received = '0; word_rx_complete = 1'b0;
        loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        tick(); tick();
        chk("reset_regs",   64'(regs_flat == '0), 64'd1);
        chk("reset_state",  64'(dut.r_state), 64'(IDLE));
        chk("reset_wto",    64'(word_to_output), 64'd0);
        chk("reset_ack",    64'(loc_ack), 64'd0);
        chk("reset_strobe", 64'(spi_wr_strobe), 64'd0);
        chk("reset_bad",    64'(bad_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // SPI write of reg3
        spi_cmd(8'h83);
        chk("wr_state_await", 64'(dut.r_state), 64'(AWAIT_DATA));
        spi_word(32'hCAFEF00D);
        chk("wr_state_commit", 64'(dut.r_state), 64'(COMMIT));
        tick();
        chk("wr_reg3",   64'(reg_of(3)), 64'hCAFEF00D);
        chk("wr_strobe", 64'(spi_wr_strobe), 64'd1);
        chk("wr_addr",   64'(spi_wr_addr), 64'd3);
        tick();
        chk("wr_strobe_clear", 64'(spi_wr_strobe), 64'd0);

        // SPI read of reg3: response one cycle after command_ready
        spi_cmd(8'h03);
        chk("rd_wto", 64'(word_to_output), 64'hCAFEF00D);
        spi_word(32'h0);
        tick();
        chk("rd_reg3",      64'(reg_of(3)), 64'hCAFEF00D);
        chk("rd_no_strobe", 64'(spi_wr_strobe), 64'd0);
        chk("rd_no_bad",    64'(bad_addr), 64'd0);

        // Local write to reg5 colliding with an SPI commit to reg5
        spi_cmd(8'h85);
        spi_word(32'd2);
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 7'd5; loc_wdata = 32'd1;
        tick();
        chk("cf_spi_first", 64'(reg_of(5)), 64'd2);
        chk("cf_no_ack",    64'(loc_ack), 64'd0);
        tick();
        chk("cf_loc_write", 64'(reg_of(5)), 64'd1);
        chk("cf_ack",       64'(loc_ack), 64'd1);
        chk("cf_rdata_old", 64'(loc_rdata), 64'd2);
        loc_req = 1'b0; loc_we = 1'b0;
        tick();
        chk("cf_ack_once", 64'(loc_ack), 64'd0);
        chk("cf_final",    64'(reg_of(5)), 64'd1);

        // Local write reg2, local reads in and out of range
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 7'd2; loc_wdata = 32'h12345678;
        tick();
        loc_req = 1'b0; loc_we = 1'b0;
        chk("lw_reg2", 64'(reg_of(2)), 64'h12345678);
        tick();
        loc_req = 1'b1; loc_addr = 7'd3;
        tick();
        loc_req = 1'b0;
        chk("lr_ack",   64'(loc_ack), 64'd1);
        chk("lr_rdata", 64'(loc_rdata), 64'hCAFEF00D);
        tick();
        snap = regs_flat;
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 7'd20; loc_wdata = 32'hFFFF0000;
        tick();
        loc_req = 1'b0; loc_we = 1'b0;
        chk("lw_oor_ignored", 64'(regs_flat == snap), 64'd1);
        tick();
        loc_req = 1'b1; loc_addr = 7'd20;
        tick();
        loc_req = 1'b0;
        chk("lr_oor_zero", 64'(loc_rdata), 64'd0);
        tick();

        // Out-of-range SPI write
        snap = regs_flat;
        spi_cmd(8'hA0);
        chk("bad_wto", 64'(word_to_output), 64'd0);
        spi_word(32'hFFFFFFFF);
        tick();
        chk("bad_pulse",     64'(bad_addr), 64'd1);
        chk("bad_no_strobe", 64'(spi_wr_strobe), 64'd0);
        chk("bad_regs",      64'(regs_flat == snap), 64'd1);
        tick();
        chk("bad_clear", 64'(bad_addr), 64'd0);

        // Address 7F: statistics word or ordinary out-of-range address
        spi_cmd(8'h7F);
`ifdef SPI_REG_STATS_EN
        chk("stats_word", 64'(word_to_output), 64'h01000004);
`else
        chk("7f_wto", 64'(word_to_output), 64'd0);
`endif
        spi_word(32'h0);
        tick();
`ifdef SPI_REG_STATS_EN
        chk("stats_no_bad", 64'(bad_addr), 64'd0);
`else
        chk("7f_bad", 64'(bad_addr), 64'd1);
`endif
        tick();

        // Abort: write command without data, then a read
        spi_cmd(8'h81);
        spi_cmd(8'h02);
        chk("ab_wto", 64'(word_to_output), 64'h12345678);
        spi_word(32'hDEADBEEF);
        tick();
        chk("ab_reg1",      64'(reg_of(1)), 64'd0);
        chk("ab_reg2",      64'(reg_of(2)), 64'h12345678);
        chk("ab_no_strobe", 64'(spi_wr_strobe), 64'd0);

        // command_ready and word_rx_complete together: command wins
        spi_cmd(8'h84);
        command = 8'h05; command_ready = 1'b1;
        word_received = 32'h55; word_rx_complete = 1'b1;
        tick();
        command_ready = 1'b0; word_rx_complete = 1'b0;
        chk("co_state", 64'(dut.r_state), 64'(AWAIT_DATA));
        chk("co_wto",   64'(word_to_output), 64'd1);
        spi_word(32'h77);
        tick();
        chk("co_reg4", 64'(reg_of(4)), 64'd0);
        chk("co_reg5", 64'(reg_of(5)), 64'd1);

        // Reset in COMMIT abandons the write
        spi_cmd(8'h87);
        spi_word(32'hAAAA5555);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rm_reg7",   64'(reg_of(7)), 64'd0);
        chk("rm_regs",   64'(regs_flat == '0), 64'd1);
        chk("rm_state",  64'(dut.r_state), 64'(IDLE));
        chk("rm_strobe", 64'(spi_wr_strobe), 64'd0);
        tick();
        chk("rm_after", 64'(reg_of(7)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_register_controller.md
SPI_REGISTER_CONTROLLER -- requirements
Module: spi_register_controller

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: data word width.
REQ-002 SHALL have parameter COMMAND_SIZE, default 8: command byte width.
REQ-003 SHALL have parameter NUM_REGS, default 16, range 1..127: number of register-bank entries.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 command  in  COMMAND_SIZE  command byte from SPI slave core; bit7 = write (1) / read (0), bits6:0 = address.
REQ-007 command_ready  in  1  one-cycle pulse; command is valid.
REQ-008 word_received  in  WORD_SIZE  data word from SPI slave core.
REQ-009 word_rx_complete  in  1  one-cycle pulse; word_received is valid.
REQ-010 word_to_output  out  WORD_SIZE  response word; the core samples it 2 cycles after command_ready.
REQ-011 loc_req, loc_we  in  1 each  local-fabric access request and write enable.
REQ-012 loc_addr  in  7  local access address; loc_wdata  in  WORD_SIZE  local write data.
REQ-013 loc_ack  out  1  one-cycle grant pulse; loc_rdata  out  WORD_SIZE  read data, valid with loc_ack.
REQ-014 regs_flat  out  NUM_REGS*WORD_SIZE  live register contents; register i occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-015 spi_wr_strobe  out  1  one-cycle pulse when an SPI write commits; spi_wr_addr  out  7  address of that write.
REQ-016 bad_addr  out  1  one-cycle pulse on any SPI access to an address >= NUM_REGS.

Function
REQ-017 FSM states SHALL be IDLE, AWAIT_DATA, COMMIT.
REQ-018 In IDLE, command_ready SHALL latch command into cmd_q and move to AWAIT_DATA.
REQ-019 On that same edge, word_to_output SHALL load reg[addr], or 0 if addr >= NUM_REGS, so it is valid 1 cycle after command_ready.
REQ-020 In AWAIT_DATA, word_rx_complete SHALL move to COMMIT.
REQ-021 In AWAIT_DATA, command_ready SHALL restart as in IDLE; this covers a transaction aborted by CS.
REQ-022 In COMMIT with a write command and a valid address, word_received SHALL be written to reg[addr], spi_wr_strobe pulsed, and the FSM returned to IDLE.
REQ-023 In COMMIT with a read command, the register bank SHALL be left unchanged.
REQ-024 bad_addr SHALL pulse in COMMIT for any out-of-range address; out-of-range writes SHALL be discarded.
REQ-025 Arbitration: an SPI commit SHALL have priority; a pending loc_req SHALL be served on the first cycle the FSM is not in COMMIT.
REQ-026 A served local write SHALL update the register on that edge.
REQ-027 loc_ack SHALL pulse the next cycle, with loc_rdata = register value before any same-edge write; out-of-range local writes SHALL be ignored and local reads SHALL return 0.
REQ-028 loc_req SHALL be held by the requester until loc_ack; at most one grant per request.
REQ-029 If command_ready and word_rx_complete coincide, command_ready SHALL win.
REQ-030 A local write to the address being read SHALL NOT alter word_to_output once it is loaded.

Reset
REQ-031 rst_n low SHALL force IDLE and clear all registers, word_to_output, loc_rdata and cmd_q to 0.
REQ-032 rst_n low SHALL deassert loc_ack, spi_wr_strobe and bad_addr.
REQ-033 Reset mid-transaction SHALL abandon the transaction; no write from it commits.

Configuration
REQ-034 SPI_REG_STATS_EN defined: address 7'h7F SHALL read {err_cnt[7:0], 8'h00, txn_cnt[15:0]}, read-only, valid even when 7'h7F >= NUM_REGS, with no bad_addr for that address.
REQ-035 With SPI_REG_STATS_EN: txn_cnt SHALL increment each COMMIT, err_cnt each bad_addr; both wrap and reset to 0.
REQ-036 SPI_REG_STATS_EN undefined: address 7'h7F SHALL be treated as any other address.

Structure
REQ-037 Package spi_reg_pkg SHALL hold the FSM state encoding, the STATS_ADDR constant (7'h7F) and the command-bit positions (write flag, address field).
REQ-038 A sub-module spi_reg_arbiter SHALL implement the SPI/local arbitration; the register bank stays in the top module.

Verification
REQ-039 Reset: hold rst_n low 2 cycles; regs_flat = 0, state = IDLE.
REQ-040 Write: command 8'h83 then word 32'hCAFEF00D; reg3 = CAFEF00D, spi_wr_strobe with spi_wr_addr = 3.
REQ-041 Read: command 8'h03; word_to_output = CAFEF00D exactly 1 cycle later; reg3 unchanged.
REQ-042 Conflict: loc_req write reg5 = 1 in the same cycle as an SPI COMMIT to reg5 = 2; SPI commits first, local write lands next cycle, final reg5 = 1, loc_ack 1 cycle after the grant.
REQ-043 Bad address: command 8'hA0 (write, addr 32), NUM_REGS = 16; bad_addr pulses, regs unchanged, stats read gives err_cnt = 1 when SPI_REG_STATS_EN is defined.
REQ-044 Abort: command 8'h81 with no data word, then command 8'h02; no write to reg1, and the read of reg2 completes normally.
